// File: rtl/imm_encode.sv
// Two-stage RISC-V instruction encoder: packs a sign-extended immediate plus register/funct fields into an instruction word.
// Optional macro IMM_ENCODE_ROUNDTRIP_CHECK_EN adds err_rt, a re-extension cross-check of the packed word.
module imm_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [1:0]       immsrc,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err_range,
    output logic             err_align,
`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
    output logic             err_rt,
`endif
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        s1_valid;
    logic [31:0] s1_imm;
    logic [1:0]  s1_src;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic        s2_valid;
    logic        s1_adv;
    logic        out_fire;

    logic [31:0] pack;
    logic        rng_bad;
    logic        aln_bad;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= '0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_imm <= imm;
                s1_src <= immsrc;
                s1_op  <= opcode;
                s1_rd  <= rd;
                s1_rs1 <= rs1;
                s1_rs2 <= rs2;
                s1_f3  <= funct3;
            end
        end
    end

    // Range: the bits above the format's top immediate bit must all copy the sign.
    always_comb begin
        rng_bad = 1'b0;
        aln_bad = 1'b0;
        case (s1_src)
            FMT_I, FMT_S: rng_bad = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            FMT_B: begin
                rng_bad = !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
                aln_bad = s1_imm[0];
            end
            default: begin
                rng_bad = !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
                aln_bad = s1_imm[0];
            end
        endcase
    end

    always_comb begin
        pack = '0;
        case (s1_src)
            FMT_I: pack = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            FMT_S: pack = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            FMT_B: pack = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                           s1_imm[4:1], s1_imm[11], s1_op};
            default: pack = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_rd, s1_op};
        endcase
    end

`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
    logic [31:0] rt_ext;
    logic        rt_bad;

    always_comb begin
        rt_ext = '0;
        case (s1_src)
            FMT_I: rt_ext = {{20{pack[31]}}, pack[31:20]};
            FMT_S: rt_ext = {{20{pack[31]}}, pack[31:25], pack[11:7]};
            FMT_B: rt_ext = {{19{pack[31]}}, pack[31], pack[7], pack[30:25], pack[11:8], 1'b0};
            default: rt_ext = {{11{pack[31]}}, pack[31], pack[19:12], pack[20], pack[30:21], 1'b0};
        endcase
    end

    // Only meaningful for legal requests; illegal ones already carry their own flag.
    assign rt_bad = (rt_ext != s1_imm) && !rng_bad && !aln_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_rt <= 1'b0;
        end else if (s1_adv && s1_valid) begin
            err_rt <= rt_bad;
        end
    end

    logic any_err;
    assign any_err = err_range || err_align || err_rt;
`else
    logic any_err;
    assign any_err = err_range || err_align;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            instr     <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                instr     <= pack;
                err_range <= rng_bad;
                err_align <= aln_bad;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_fire) begin
            if (enc_count != '1) begin
                enc_count <= enc_count + CNT_ONE;
            end
            if (any_err && (err_count != '1)) begin
                err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed vector table, backpressure/reset sequences, randomized scoreboard run.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [1:0]  immsrc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err_range, err_align;
    logic [15:0] enc_count, err_count;
`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
    logic        err_rt;
`endif

    imm_encode #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .immsrc(immsrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .err_range(err_range), .err_align(err_align),
`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
        .err_rt(err_rt),
`endif
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] exp_instr;
        logic        exp_rng, exp_aln;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        rng, aln;
    } exp_t;

    int errors = 0;
    int checks = 0;
    int exp_enc = 0;
    int exp_err = 0;
    vec_t tbl[7];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: field placement by masks/shifts, range by signed bounds.
    function automatic logic [31:0] ref_enc(input logic [1:0] fmt, input logic [31:0] im,
                                            input logic [6:0] op, input logic [4:0] d,
                                            input logic [4:0] a, input logic [4:0] b,
                                            input logic [2:0] f);
        int unsigned u = im;
        int unsigned w = op;
        case (fmt)
            2'd0: w += ((u & 'hFFF) << 20) + (a << 15) + (f << 12) + (d << 7);
            2'd1: w += (((u >> 5) & 'h7F) << 25) + (b << 20) + (a << 15) + (f << 12)
                       + ((u & 'h1F) << 7);
            2'd2: w += (((u >> 12) & 1) << 31) + (((u >> 5) & 'h3F) << 25) + (b << 20)
                       + (a << 15) + (f << 12) + (((u >> 1) & 'hF) << 8) + (((u >> 11) & 1) << 7);
            default: w += (((u >> 20) & 1) << 31) + (((u >> 1) & 'h3FF) << 21)
                       + (((u >> 11) & 1) << 20) + (((u >> 12) & 'hFF) << 12) + (d << 7);
        endcase
        return w;
    endfunction

    function automatic logic ref_rng(input logic [1:0] fmt, input logic [31:0] im);
        int s = im;
        case (fmt)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4095);
            default:    return (s < -(1 << 20)) || (s > (1 << 20) - 1);
        endcase
    endfunction

    function automatic logic ref_aln(input logic [1:0] fmt, input logic [31:0] im);
        return (fmt >= 2'd2) && (im % 2 == 1);
    endfunction

    task automatic drive(input vec_t v);
        immsrc = v.fmt; imm = v.imm; opcode = v.op;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; funct3 = v.f3;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        drive(v); in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_lat1_vld"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_vld"}, 32'(out_valid), 32'd1);
        chk({nm, "_instr"}, instr, v.exp_instr);
        chk({nm, "_rng"}, 32'(err_range), 32'(v.exp_rng));
        chk({nm, "_aln"}, 32'(err_align), 32'(v.exp_aln));
        exp_enc++;
        if (v.exp_rng || v.exp_aln) exp_err++;
        @(negedge clk);
        chk({nm, "_enc_cnt"}, 32'(enc_count), 32'(exp_enc));
        chk({nm, "_err_cnt"}, 32'(err_count), 32'(exp_err));
        chk({nm, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        fmt   imm           op     rd  rs1 rs2 f3  instr         rng  aln
        tbl[0] = '{2'd0, 32'hFFFFFFFF, 7'h13, 5, 0, 0, 0, 32'hFFF00293, 1'b0, 1'b0};
        tbl[1] = '{2'd1, 32'h00000008, 7'h23, 0, 2, 6, 2, 32'h00612423, 1'b0, 1'b0};
        tbl[2] = '{2'd2, 32'hFFFFFFFC, 7'h63, 0, 4, 4, 0, 32'hFE420EE3, 1'b0, 1'b0};
        tbl[3] = '{2'd3, 32'h00000800, 7'h6F, 1, 0, 0, 0, 32'h001000EF, 1'b0, 1'b0};
        tbl[4] = '{2'd0, 32'h00000800, 7'h13, 1, 2, 0, 0, 32'h80010093, 1'b1, 1'b0};
        tbl[5] = '{2'd2, 32'h00000003, 7'h63, 0, 1, 2, 1, 32'h00209163, 1'b0, 1'b1};
        tbl[6] = '{2'd3, 32'h00100001, 7'h6F, 0, 0, 0, 0, 32'h8000006F, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        imm = '0; immsrc = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_instr", instr, 32'd0);
        chk("rst_enc_cnt", 32'(enc_count), 32'd0);
        chk("rst_err_cnt", 32'(err_count), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while both stages are full and the output is stalled.
        @(negedge clk);
        out_ready = 1'b0; drive(tbl[1]); in_valid = 1'b1;
        @(negedge clk);
        drive(tbl[2]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_enc_cnt", 32'(enc_count), 32'd0);
        chk("midrst_err_cnt", 32'(err_count), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0; exp_enc = 0; exp_err = 0;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        run_vec(tbl[3], "postrst");

        // Three back-to-back requests into a stalled output.
        @(negedge clk);
        out_ready = 1'b0; drive(tbl[1]); in_valid = 1'b1;
        #1 chk("bp_acc_a", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(tbl[2]);
        #1 chk("bp_acc_b", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(tbl[0]);
        #1 chk("bp_block_c", 32'(in_ready), 32'd0);
        chk("bp_hold_a", instr, tbl[1].exp_instr);
        @(negedge clk);
        chk("bp_still_block", 32'(in_ready), 32'd0);
        chk("bp_stable_vld", 32'(out_valid), 32'd1);
        chk("bp_stable_a", instr, tbl[1].exp_instr);
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b_vld", 32'(out_valid), 32'd1);
        chk("bp_b", instr, tbl[2].exp_instr);
        @(negedge clk);
        chk("bp_c_vld", 32'(out_valid), 32'd1);
        chk("bp_c", instr, tbl[0].exp_instr);
        @(negedge clk);
        exp_enc += 3;
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_enc_cnt", 32'(enc_count), 32'(exp_enc));

        // Randomized traffic against the reference model.
        begin
            int n = 1000, sent = 0, recv = 0, cyc = 0;
            bit have = 0, held = 0;
            logic [31:0] held_instr = '0;
            vec_t cur;
            exp_t e, got;
            while (recv < n && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                if (!have && sent < n) begin
                    cur.fmt = 2'($urandom_range(0, 3));
                    case (cur.fmt)
                        2'd0, 2'd1: cur.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
                        2'd2: cur.imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
                        default: cur.imm = 32'(($signed($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
                    endcase
                    if ($urandom_range(0, 4) == 0) cur.imm = $urandom;
                    cur.op = 7'($urandom); cur.rd = 5'($urandom); cur.rs1 = 5'($urandom);
                    cur.rs2 = 5'($urandom); cur.f3 = 3'($urandom);
                    have = 1;
                end
                drive(cur);
                in_valid = have && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (held) begin
                    chk("rnd_hold_vld", 32'(out_valid), 32'd1);
                    chk("rnd_hold_instr", instr, held_instr);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("rnd_unexpected_word", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        got.instr = instr;
                        chk("rnd_instr", got.instr, e.instr);
                        chk("rnd_rng", 32'(err_range), 32'(e.rng));
                        chk("rnd_aln", 32'(err_align), 32'(e.aln));
`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
                        chk("rnd_err_rt", 32'(err_rt), 32'd0);
`endif
                        exp_enc++;
                        if (e.rng || e.aln) exp_err++;
                    end
                    recv++;
                end
                held = out_valid && !out_ready;
                held_instr = instr;
                if (in_valid && in_ready) begin
                    e.instr = ref_enc(cur.fmt, cur.imm, cur.op, cur.rd, cur.rs1, cur.rs2, cur.f3);
                    e.rng = ref_rng(cur.fmt, cur.imm);
                    e.aln = ref_aln(cur.fmt, cur.imm);
                    sb.push_back(e);
                    have = 0;
                    sent++;
                end
            end
            chk("rnd_all_received", 32'(recv), 32'(n));
            in_valid = 1'b0;
            @(negedge clk);
            chk("rnd_enc_cnt", 32'(enc_count), 32'(exp_enc));
            chk("rnd_err_cnt", 32'(err_count), 32'(exp_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Pipelined RISC-V instruction encoder. It is the inverse of the immediate extender: it takes a 32-bit sign-extended immediate, an immsrc format code and register/function fields, and packs them into a 32-bit instruction word.
- Used by the self-test / boot-loader instruction generator that writes the instruction memory.
- Two-stage valid/ready pipeline. Stage 1 runs range and alignment checks; stage 2 packs the fields and registers the result.

Parameters:
- CNT_W, 16, width of the saturating encoded-instruction and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- imm  in  32  sign-extended immediate value.
- immsrc  in  2  format: 00 I, 01 S, 10 B, 11 J (same coding as the extender).
- opcode  in  7  instr[6:0].
- rd  in  5  destination register (I, J).
- rs1  in  5  source 1 (I, S, B).
- rs2  in  5  source 2 (S, B).
- funct3  in  3  funct3 (I, S, B).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- instr  out  32  encoded instruction.
- err_range  out  1  immediate does not fit the format; qualified by out_valid.
- err_align  out  1  B/J immediate is odd; qualified by out_valid.
- enc_count  out  CNT_W  words delivered (out_valid & out_ready), saturating.
- err_count  out  CNT_W  delivered words with any error flag set, saturating.

Behaviour:
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - Stage 1 advances into stage 2 only when s1_adv is high.
  - Payload and out_valid are held stable while out_valid & !out_ready.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 word/cycle.
- Ordering: strict FIFO order. Nothing is dropped or duplicated under backpressure.
- Field packing, with the opcode always in [6:0]:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
- Range check (err_range=1 when the listed bits are not all equal):
  - I and S: imm[31:11].
  - B: imm[31:12].
  - J: imm[31:20].
- Alignment check: err_align = imm[0] for B and J; always 0 for I and S.
- Erroneous requests are still encoded from the truncated bits and delivered with their flags set. The encoder never stalls on an error.
- Counters:
  - Increment only on an output transfer; they hold at all-ones.
  - err_count increments when err_range | err_align is set on the transferred word.
- Reset (asynchronous, any time, including mid-transfer or mid-stall):
  - Both stage valids clear.
  - out_valid=0, in_ready=1 from the first edge after release.
  - instr, err_range, err_align, enc_count and err_count all reset to 0.
  - Any in-flight words are discarded.

Optional Feature:
- Macro: IMM_ENCODE_ROUNDTRIP_CHECK_EN.
- When defined:
  - Stage 2 re-extends the packed word using the extender's immsrc rules and compares the result with the stage-1 imm.
  - Output err_rt (1 bit, reset 0, qualified by out_valid) = mismatch & !err_range & !err_align.
  - err_rt also increments err_count.
- When undefined: no err_rt port, no comparator logic, and counter behaviour is exactly as above.

Test Plan:
- I, imm=0xFFFFFFFF, opcode=0x13, rd=5, rs1=0, funct3=0 -> instr=0xFFF00293 two cycles later; both error flags 0.
- S, imm=8, opcode=0x23, rs1=2, rs2=6, funct3=2 -> 0x00612423. B, imm=0xFFFFFFFC, opcode=0x63, rs1=rs2=4, funct3=0 -> 0xFE420EE3. J, imm=0x800, rd=1, opcode=0x6F -> 0x001000EF.
- I, imm=0x800 -> err_range=1, instr[31:20]=0x800, err_count=1. B, imm=3 -> err_align=1, err_range=0, err_count=2.
- Issue 3 back-to-back valid requests with out_ready=0 -> in_ready drops after 2 are accepted. Release out_ready -> all 3 words emerge in order over 3 consecutive cycles; enc_count=3.
- Pulse reset while s1 and s2 are both full and out_ready=0 -> out_valid=0 and all counters=0 immediately. A new request afterwards emerges with 2-cycle latency.
- Macro defined, 1000 random in-range, aligned requests across all formats -> err_rt never asserted and instr matches the reference model on every word.
